// File: rtl/gsd_pkg.sv
// Shared state encoding, width helpers and saturation constant for the
// parametrised Goldschmidt divider.
package gsd_pkg;

  typedef logic [1:0] gsd_state_t;

  localparam gsd_state_t IDLE = 2'd0;
  localparam gsd_state_t ITER = 2'd1;
  localparam gsd_state_t DONE = 2'd2;

  localparam logic [255:0] GSD_SAT_ALL = '1;

  function automatic int gsd_fw(input int width, input int guard);
    return width + guard;
  endfunction

  function automatic int gsd_cnt_w(input int iters);
    return $clog2(iters + 1);
  endfunction

endpackage

// File: rtl/gsd_step.sv
// One combinational Goldschmidt iteration on 1.FW fixed-point values:
// f = 2 - y, x' = trunc(x*f), y' = trunc(y*f), saturating on integer overflow.
module gsd_step #(
  parameter int FW = 34
) (
  input  logic [FW:0] x_i,
  input  logic [FW:0] y_i,
  output logic [FW:0] x_o,
  output logic [FW:0] y_o,
  output logic [FW:0] f_o
);

  logic [FW:0]     f;
  logic [2*FW+1:0] px;
  logic [2*FW+1:0] py;
  logic            unused_lo;

  // 2 - y wraps cleanly in FW+1 bits because y lies in (0,1].
  assign f  = -y_i;
  assign px = {{(FW+1){1'b0}}, x_i} * {{(FW+1){1'b0}}, f};
  assign py = {{(FW+1){1'b0}}, y_i} * {{(FW+1){1'b0}}, f};

  assign x_o = px[2*FW+1] ? {(FW+1){1'b1}} : px[2*FW:FW];
  assign y_o = py[2*FW+1] ? {(FW+1){1'b1}} : py[2*FW:FW];
  assign f_o = f;

  assign unused_lo = ^{px[FW-1:0], py[FW-1:0]};

endmodule

// File: rtl/goldschmidt_divider_param.sv
// Iterative Goldschmidt fractional divider q = a/b (a in [0,1), b in [0.5,1)).
// Optional early exit on converged divisor: define GSD_EARLY_EXIT_EN.
//
// state | meaning
// IDLE  | waiting for start; operands sampled here
// ITER  | one Goldschmidt step per cycle (or a single fault-hold cycle when err)
// DONE  | one-cycle ready pulse, then back to IDLE
module goldschmidt_divider_param
  import gsd_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = 5,
  parameter int GUARD = 2
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             ready,
  output logic             err,
  output logic [WIDTH-1:0] yn
);

  localparam int FW = gsd_fw(WIDTH, GUARD);
  localparam int CW = gsd_cnt_w(ITERS);
  localparam logic [CW-1:0]    CNT_LAST = CW'(ITERS - 1);
  localparam logic [WIDTH-1:0] Q_SAT    = GSD_SAT_ALL[WIDTH-1:0];

  gsd_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [FW:0]      x_q, x_d, y_q, y_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             err_q, err_d;
  logic [FW:0]      x_n, y_n, f_n;
  logic             early_exit;

  gsd_step #(.FW(FW)) u_step (
    .x_i (x_q),
    .y_i (y_q),
    .x_o (x_n),
    .y_o (y_n),
    .f_o (f_n)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    x_d        = x_q;
    y_d        = y_q;
    q_d        = q_q;
    err_d      = err_q;
`ifdef GSD_EARLY_EXIT_EN
    early_exit = (y_q[FW-1:0] == {FW{1'b1}});
`else
    early_exit = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = '0;
          state_d = ITER;
          if (b[WIDTH-1]) begin
            x_d   = (FW+1)'(a) << GUARD;
            y_d   = (FW+1)'(b) << GUARD;
            err_d = 1'b0;
          end else begin
            // Fault: park one cycle in ITER with busy masked, then report.
            err_d = 1'b1;
            q_d   = Q_SAT;
          end
        end
      end
      ITER: begin
        if (err_q) begin
          state_d = DONE;
        end else if (early_exit) begin
          state_d = DONE;
          q_d     = x_q[FW -: WIDTH];
        end else begin
          x_d   = x_n;
          y_d   = y_n;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
            q_d     = x_n[FW -: WIDTH];
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      q_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      q_q     <= q_d;
      err_q   <= err_d;
    end
  end

  assign busy  = (state_q == ITER) && !err_q;
  assign ready = (state_q == DONE);
  assign q     = q_q;
  assign err   = err_q;
  assign yn    = y_q[FW-1:GUARD];

endmodule

// File: tb/tb_goldschmidt_divider_param.sv
// Self-checking bench for goldschmidt_divider_param (WIDTH=32, ITERS=5, GUARD=2);
// results are compared against the exact quotient a*2^31/b.
module tb_goldschmidt_divider_param;

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] a, b;
  logic        start;
  logic [31:0] q, yn;
  logic        busy, ready, err;

  int checks = 0;
  int errors = 0;

  goldschmidt_divider_param #(.WIDTH(32), .ITERS(5), .GUARD(2)) dut (
    .clk   (clk),
    .clrn  (clrn),
    .a     (a),
    .b     (b),
    .start (start),
    .q     (q),
    .busy  (busy),
    .ready (ready),
    .err   (err),
    .yn    (yn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Exact quotient in 1.31 format; truncation inside the iterations
  // leaves the hardware a few ulp short of (or just above) it.
  function automatic bit q_ok(input logic [31:0] ta, input logic [31:0] tb, input logic [31:0] tq);
    longint ideal, got;
    ideal = (longint'(ta) << 31) / longint'(tb);
    if (ideal > 64'h0000_0000_FFFF_FFFF) ideal = 64'h0000_0000_FFFF_FFFF;
    got = longint'(tq);
    return (got + 4 >= ideal) && (got <= ideal + 2);
  endfunction

  function automatic bit lat_ok(input int k);
`ifdef GSD_EARLY_EXIT_EN
    return (k >= 1) && (k <= 5);
`else
    return k == 5;
`endif
  endfunction

  // Returns at the falling edge just after the accept edge N.
  task automatic launch(input logic [31:0] ta, input logic [31:0] tb);
    @(negedge clk);
    a = ta; b = tb; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready(inout int k, inout logic sb);
    while (!ready && k < 60) begin
      sb = sb | busy;
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    int          k, k1;
    logic        sb, saw_rdy;
    logic [31:0] ta, tb;

    clrn = 1'b0; start = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 0);
    chk("rst_err", err, 0);
    chk("rst_yn", yn, 0);
    @(negedge clk) clrn = 1'b1;

    // 0.75 / 0.5 -> 1.5, full latency
    launch(32'hC000_0000, 32'h8000_0000);
    k = 0; sb = 1'b0;
    wait_ready(k, sb);
    chk("lat_075_05", k, 5);
    chk("q_075_05", q_ok(32'hC000_0000, 32'h8000_0000, q), 1);
    chk("err_075_05", err, 0);
    chk("busy_seen", sb, 1);
    @(negedge clk);
    chk("ready_pulse", ready, 0);

    // 0.5 / 0.75 -> 0.6667
    launch(32'h8000_0000, 32'hC000_0000);
    k = 0; sb = 1'b0;
    wait_ready(k, sb);
    chk("lat_05_075", k, 5);
    chk("q_05_075", q_ok(32'h8000_0000, 32'hC000_0000, q), 1);
    chk("err_05_075", err, 0);

    // divisor faults: unnormalised and zero
    launch(32'h1234_5678, 32'h4000_0000);
    k = 0; sb = 1'b0;
    wait_ready(k, sb);
    chk("lat_fault_unnorm", k, 1);
    chk("err_fault_unnorm", err, 1);
    chk("q_fault_unnorm", q, 32'hFFFF_FFFF);
    chk("busy_fault_unnorm", sb, 0);
    launch(32'h1234_5678, 32'h0);
    k = 0; sb = 1'b0;
    wait_ready(k, sb);
    chk("lat_fault_zero", k, 1);
    chk("err_fault_zero", err, 1);
    chk("q_fault_zero", q, 32'hFFFF_FFFF);
    chk("busy_fault_zero", sb, 0);
    @(negedge clk);
    chk("err_hold", err, 1);

    // start pulsed at N+2 while busy must be ignored
    launch(32'hC000_0000, 32'h8000_0000);
    k = 0; sb = 1'b0;
    @(negedge clk); k = 1;
    a = 32'h1111_1111; b = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk); k = 2;
    start = 1'b0; a = 32'h0; b = 32'h0;
    wait_ready(k, sb);
    chk("lat_ignore", k, 5);
    chk("q_ignore", q_ok(32'hC000_0000, 32'h8000_0000, q), 1);
    chk("err_ignore", err, 0);
    launch(32'h4000_0000, 32'hA000_0000);
    k = 0; sb = 1'b0;
    wait_ready(k, sb);
    chk("lat_after_ignore", k, 5);
    chk("q_after_ignore", q_ok(32'h4000_0000, 32'hA000_0000, q), 1);

    // asynchronous reset mid-division
    launch(32'h9000_0000, 32'hB000_0000);
    @(posedge clk); @(posedge clk); @(posedge clk);
    #2 clrn = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_q", q, 0);
    chk("midrst_yn", yn, 0);
    chk("midrst_ready", ready, 0);
    chk("midrst_err", err, 0);
    @(negedge clk) clrn = 1'b1;
    saw_rdy = 1'b0;
    repeat (10) begin
      @(negedge clk);
      saw_rdy = saw_rdy | ready;
    end
    chk("midrst_no_ready", saw_rdy, 0);
    launch(32'h9000_0000, 32'hB000_0000);
    k = 0; sb = 1'b0;
    wait_ready(k, sb);
    chk("lat_post_rst", k, 5);
    chk("q_post_rst", q_ok(32'h9000_0000, 32'hB000_0000, q), 1);

    // zero dividend
    launch(32'h0, 32'hFFFF_FFFF);
    k = 0; sb = 1'b0;
    wait_ready(k, sb);
    chk("lat_zero_a", lat_ok(k), 1);
    chk("q_zero_a", q, 0);
    chk("err_zero_a", err, 0);
`ifdef GSD_EARLY_EXIT_EN
    chk("early_exit_short", k < 5, 1);
`endif

    // start held high: back-to-back acceptance each return to IDLE
    @(negedge clk);
    a = 32'hC000_0000; b = 32'h8000_0000; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    k = 0; sb = 1'b0;
    wait_ready(k, sb);
    k1 = k;
    chk("held_lat1", k1, 5);
    @(negedge clk); k++;
    wait_ready(k, sb);
    start = 1'b0;
    chk("held_spacing", k - k1, 7);
    chk("held_q", q_ok(32'hC000_0000, 32'h8000_0000, q), 1);
    @(negedge clk);

    // randomized normalised divisions
    for (int i = 0; i < 16; i++) begin
      ta = $urandom;
      tb = $urandom | 32'h8000_0000;
      launch(ta, tb);
      k = 0; sb = 1'b0;
      wait_ready(k, sb);
      chk("rand_lat", lat_ok(k), 1);
      chk("rand_q", q_ok(ta, tb, q), 1);
      chk("rand_err", err, 0);
    end

    // randomized faults
    for (int i = 0; i < 4; i++) begin
      ta = $urandom;
      tb = $urandom & 32'h7FFF_FFFF;
      launch(ta, tb);
      k = 0; sb = 1'b0;
      wait_ready(k, sb);
      chk("rand_fault_lat", k, 1);
      chk("rand_fault_err", err, 1);
      chk("rand_fault_q", q, 32'hFFFF_FFFF);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
